// File: rtl/cla_seq_pkg.sv
// ---------------------------------------------------------------------------
// cla_seq_pkg
// Shared definitions for the nibble-serial carry-lookahead adder:
//   state_t : controller states (IDLE, RUN, DONE)
//   NIBBLE  : width of the shared lookahead slice, in bits
// ---------------------------------------------------------------------------
package cla_seq_pkg;

  localparam int NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : cla_seq_pkg

// File: rtl/cla_4bit.sv
// ---------------------------------------------------------------------------
// cla_4bit
// Combinational 4-bit carry-lookahead adder. Every internal carry is formed
// directly from generate/propagate terms, so there is no ripple chain.
// Ports:
//   i_a, i_b : 4-bit operands
//   i_cin    : carry-in
//   o_sum    : 4-bit sum
//   o_cout   : carry out of bit 3
// ---------------------------------------------------------------------------
module cla_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout
);

  logic [3:0] w_p;
  logic [3:0] w_g;
  logic [3:0] w_c;

  assign w_p = i_a ^ i_b;
  assign w_g = i_a & i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & i_cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_cout = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_cin);

  assign o_sum = w_p ^ w_c;

endmodule : cla_4bit

// File: rtl/cla_seq_adder.sv
// ---------------------------------------------------------------------------
// cla_seq_adder
// WIDTH-bit adder that reuses one 4-bit carry-lookahead slice over
// N = WIDTH/4 cycles, least significant nibble first, with valid/ready
// handshakes on both sides. One operation in flight at a time.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operation offer / acceptance (IDLE only)
//   a, b, cin            : operands and carry-in, captured on acceptance
//   out_valid / out_ready: result offer / consumption (DONE only)
//   sum, cout, ovf       : (a+b+cin) mod 2^WIDTH, carry out, signed overflow
// ---------------------------------------------------------------------------
module cla_seq_adder
  import cla_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / NIBBLE;
  localparam int IDX_W = $clog2(N);
  localparam int MSB   = WIDTH - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t             r_state;
  state_t             w_state_next;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic               r_cout;
  logic [NIBBLE-1:0]  r_sum_nib [N];

  logic [NIBBLE-1:0]  w_a_nib [N];
  logic [NIBBLE-1:0]  w_b_nib [N];
  logic [NIBBLE-1:0]  w_slice_sum;
  logic               w_slice_cout;
  logic               w_accept;
  logic               w_last;

  // Split captured operands into nibbles and reassemble the sum from the
  // per-nibble result registers.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_nib
      assign w_a_nib[gi] = r_a[NIBBLE*gi +: NIBBLE];
      assign w_b_nib[gi] = r_b[NIBBLE*gi +: NIBBLE];
      assign sum[NIBBLE*gi +: NIBBLE] = r_sum_nib[gi];
    end
  endgenerate

  cla_4bit u_slice (
    .i_a    (w_a_nib[r_idx]),
    .i_b    (w_b_nib[r_idx]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_last   = (r_state == RUN) && (r_idx == LAST_IDX);
  assign cout     = r_cout;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    ovf          = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = RUN;
        end
      end
      RUN: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        // Same-sign operands producing a different-sign result.
        ovf = (r_a[MSB] == r_b[MSB]) && (r_sum_nib[N-1][NIBBLE-1] != r_a[MSB]);
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture and one nibble per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_cout  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_sum_nib[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b;
        r_carry <= cin;
        r_idx   <= '0;
      end
      if (r_state == RUN) begin
        r_sum_nib[r_idx] <= w_slice_sum;
        r_carry          <= w_slice_cout;
        if (w_last) begin
          r_cout <= w_slice_cout;
          r_idx  <= '0;  // park at 0 so the index never passes N-1
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

endmodule : cla_seq_adder
